// File: rtl/register_file_param_if.sv
// Bus between the control unit and the register file: read/write ports plus clear handshake.
interface register_file_param_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
);
  localparam int unsigned ADDR_W = $clog2(NREGS);

  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic              writeEnable;
  logic [XLEN-1:0]   data;
  logic              clearStart;
  logic [XLEN-1:0]   rs1Data;
  logic [XLEN-1:0]   rs2Data;
  logic              clearBusy;
  logic              clearDone;

  modport master (
    output rs1, rs2, rd, writeEnable, data, clearStart,
    input  rs1Data, rs2Data, clearBusy, clearDone
  );

  modport slave (
    input  rs1, rs2, rd, writeEnable, data, clearStart,
    output rs1Data, rs2Data, clearBusy, clearDone
  );
endinterface

// File: rtl/register_file_param.sv
// Parametrised integer register file with hardwired-zero x0 and a sequential clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file_param #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input logic                  clk,
  input logic                  reset,
  register_file_param_if.slave rf
);
  localparam int unsigned ADDR_W = $clog2(NREGS);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic              clr_en;
  logic              wr_en;

  // Valid, writable/readable index: non-zero and inside the file.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < NREGS);
  endfunction

  assign clr_en = (state_q == StClear);
  assign wr_en  = rf.writeEnable && in_range(rf.rd) && !clr_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rf.clearStart) begin
          state_d = StClear;
          idx_d   = ADDR_W'(1);
          busy_d  = 1'b1;
        end
      end
      StClear: begin
        if (32'(idx_q) == NREGS - 1) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= ADDR_W'(1);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else if (clr_en) begin
      regs_q[idx_q] <= '0;
    end else if (wr_en) begin
      regs_q[rf.rd] <= rf.data;
    end
  end

  always_comb begin
    rf.rs1Data = '0;
    rf.rs2Data = '0;
    if (in_range(rf.rs1)) rf.rs1Data = regs_q[rf.rs1];
    if (in_range(rf.rs2)) rf.rs2Data = regs_q[rf.rs2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (rf.rs1 == rf.rd)) rf.rs1Data = rf.data;
    if (wr_en && (rf.rs2 == rf.rd)) rf.rs2Data = rf.data;
`endif
  end

  assign rf.clearBusy = busy_q;
  assign rf.clearDone = done_q;
endmodule

// File: tb/tb_register_file_param.sv
// Directed self-checking bench for register_file_param on three configurations.
module tb_register_file_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_cnt;
  int   done_cnt;
  int   done_at;
  logic seen;

  register_file_param_if #(.XLEN(32), .NREGS(32)) b32 ();
  register_file_param_if #(.XLEN(32), .NREGS(20)) b20 ();
  register_file_param_if #(.XLEN(8),  .NREGS(4))  b4 ();

  register_file_param #(.XLEN(32), .NREGS(32)) dut32 (.clk(clk), .reset(reset), .rf(b32.slave));
  register_file_param #(.XLEN(32), .NREGS(20)) dut20 (.clk(clk), .reset(reset), .rf(b20.slave));
  register_file_param #(.XLEN(8),  .NREGS(4))  dut4  (.clk(clk), .reset(reset), .rf(b4.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {b32.rs1, b32.rs2, b32.rd, b32.writeEnable, b32.data, b32.clearStart} = '0;
    {b20.rs1, b20.rs2, b20.rd, b20.writeEnable, b20.data, b20.clearStart} = '0;
    {b4.rs1, b4.rs2, b4.rd, b4.writeEnable, b4.data, b4.clearStart} = '0;

    // Reset state
    tick;
    check("rst_rs1", b32.rs1Data, 32'd0);
    check("rst_rs2", b32.rs2Data, 32'd0);
    check("rst_busy", 32'(b32.clearBusy), 32'd0);
    check("rst_done", 32'(b32.clearDone), 32'd0);
    reset = 1'b0;
    tick;

    // Back-to-back writes then reads
    b32.writeEnable = 1'b1; b32.rd = 5'd1; b32.data = 32'd123;
    tick;
    b32.rd = 5'd2; b32.data = 32'd321;
    tick;
    b32.writeEnable = 1'b0; b32.rs1 = 5'd1; b32.rs2 = 5'd2;
    #1;
    check("rd_r1", b32.rs1Data, 32'd123);
    check("rd_r2", b32.rs2Data, 32'd321);
    reset = 1'b1;
    #1;
    check("midrst_r1", b32.rs1Data, 32'd0);
    check("midrst_r2", b32.rs2Data, 32'd0);
    reset = 1'b0;
    tick;

    // x0 write discarded
    b32.writeEnable = 1'b1; b32.rd = 5'd0; b32.data = 32'd2121;
    tick;
    b32.writeEnable = 1'b0; b32.rs1 = 5'd0;
    #1;
    check("x0_read", b32.rs1Data, 32'd0);

    // Out-of-range index on the 20-entry file
    b20.writeEnable = 1'b1; b20.rd = 5'd19; b20.data = 32'd77;
    tick;
    b20.rd = 5'd20; b20.data = 32'd5;
    tick;
    b20.writeEnable = 1'b0; b20.rs1 = 5'd20; b20.rs2 = 5'd19;
    #1;
    check("oor_read20", b20.rs1Data, 32'd0);
    check("oor_r19", b20.rs2Data, 32'd77);
    b20.rs1 = 5'd4;
    #1;
    check("oor_r4", b20.rs1Data, 32'd0);

    // Same-cycle write/read of reg 3
    b32.rs1 = 5'd3; b32.writeEnable = 1'b1; b32.rd = 5'd3; b32.data = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same", b32.rs1Data, 32'hA5A5A5A5);
`else
    check("byp_same", b32.rs1Data, 32'd0);
`endif
    tick;
    b32.writeEnable = 1'b0;
    #1;
    check("byp_after", b32.rs1Data, 32'hA5A5A5A5);

    // Fill 1..31 with their index, then clear
    for (int i = 1; i < 32; i++) begin
      b32.writeEnable = 1'b1; b32.rd = 5'(i); b32.data = 32'(i);
      tick;
    end
    b32.writeEnable = 1'b0; b32.rs1 = 5'd31; b32.rs2 = 5'd17;
    #1;
    check("fill_r31", b32.rs1Data, 32'd31);
    check("fill_r17", b32.rs2Data, 32'd17);
    b32.clearStart = 1'b1;
    tick;
    b32.clearStart = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (b32.clearBusy) busy_cnt++;
      if (b32.clearDone) begin done_cnt++; done_at = c; end
      b32.clearStart = (c == 3);
      b32.writeEnable = (c == 5); b32.rd = 5'd5; b32.data = 32'd7;
      if (c == 10) begin
        b32.rs1 = 5'd31; b32.rs2 = 5'd2;
        #1;
        check("mid_uncleared", b32.rs1Data, 32'd31);
        check("mid_cleared", b32.rs2Data, 32'd0);
      end
      tick;
    end
    b32.clearStart = 1'b0; b32.writeEnable = 1'b0;
    check("clr_busy_cycles", 32'(busy_cnt), 32'd31);
    check("clr_done_pulses", 32'(done_cnt), 32'd1);
    check("clr_done_at", 32'(done_at), 32'd31);
    for (int i = 0; i < 32; i++) begin
      b32.rs1 = 5'(i);
      #1;
      check($sformatf("clr_r%0d", i), b32.rs1Data, 32'd0);
    end

    // Reset in the middle of a clear
    b32.writeEnable = 1'b1; b32.rd = 5'd20; b32.data = 32'h2020;
    tick;
    b32.writeEnable = 1'b0; b32.clearStart = 1'b1;
    tick;
    b32.clearStart = 1'b0;
    for (int c = 0; c < 10; c++) tick;
    b32.rs1 = 5'd20;
    #1;
    check("rstclr_pre", b32.rs1Data, 32'h2020);
    check("rstclr_busy_pre", 32'(b32.clearBusy), 32'd1);
    reset = 1'b1;
    #1;
    check("rstclr_busy", 32'(b32.clearBusy), 32'd0);
    check("rstclr_done", 32'(b32.clearDone), 32'd0);
    check("rstclr_r20", b32.rs1Data, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      seen = seen | b32.clearDone | b32.clearBusy;
    end
    check("rstclr_quiet", 32'(seen), 32'd0);
    b32.clearStart = 1'b1;
    tick;
    b32.clearStart = 1'b0;
    check("restart_busy", 32'(b32.clearBusy), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick;
      seen = b32.clearDone;
    end
    check("restart_done", 32'(seen), 32'd1);

    // Small configuration: 8-bit x 4 entries
    b4.writeEnable = 1'b1; b4.rd = 2'd3; b4.data = 8'hFF;
    tick;
    b4.writeEnable = 1'b0; b4.rs1 = 2'd3;
    #1;
    check("small_wr", 32'(b4.rs1Data), 32'hFF);
    b4.clearStart = 1'b1;
    tick;
    b4.clearStart = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (b4.clearBusy) busy_cnt++;
      if (b4.clearDone) done_cnt++;
      tick;
    end
    check("small_busy", 32'(busy_cnt), 32'd3);
    check("small_done", 32'(done_cnt), 32'd1);
    check("small_r3", 32'(b4.rs1Data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
